// File: rtl/alu_pkg.sv
// Shared ALU op encoding and helpers for the decoder and execute-stage ALU.
package alu_pkg;

    localparam int unsigned ALU_OP_W    = 4;
    localparam int unsigned ALU_OP_LAST = 9;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    function automatic logic is_shift(alu_op_e op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Small combinational shifter: moves work by at most SHIFT_STEP bits per call.
module alu_shift_step #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 4,
    localparam int unsigned STEP_W    = $clog2(SHIFT_STEP + 1)
) (
    input  logic [XLEN-1:0]   work,
    input  logic [STEP_W-1:0] step,
    input  logic              dir,
    input  logic              arith,
    output logic [XLEN-1:0]   out
);

    // dir=0 shifts left; dir=1 shifts right, sign-filling when arith is set
    always_comb begin
        out = work;
        if (!dir) begin
            out = work << step;
        end else if (arith) begin
            out = XLEN'($signed(work) >>> step);
        end else begin
            out = work >> step;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle arithmetic/logic ops, iterative shifts,
// registered result with valid/ready handshakes on both sides.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 4,
    parameter int unsigned RD_W       = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_flush,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic [ALU_OP_W-1:0] i_alu_op,
    input  logic [XLEN-1:0]     i_operand_a,
    input  logic [XLEN-1:0]     i_operand_b,
    input  logic [RD_W-1:0]     i_rd,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [XLEN-1:0]     o_result,
    output logic [RD_W-1:0]     o_rd,
    output logic                o_illegal
);

    localparam int unsigned SHAMT_W = $clog2(XLEN);
    localparam int unsigned STEP_W  = $clog2(SHIFT_STEP + 1);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_e;

    state_e             state_q, state_d;
    logic [XLEN-1:0]    work_q, work_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic               dir_q, dir_d;
    logic               arith_q, arith_d;
    logic [RD_W-1:0]    rd_q, rd_d;
    logic               valid_d;
    logic [XLEN-1:0]    result_d;
    logic [RD_W-1:0]    out_rd_d;
    logic               illegal_d;

    alu_op_e            op;
    logic [SHAMT_W-1:0] shamt;
    logic               op_illegal;
    logic               accept;
    logic [XLEN-1:0]    sh_in, sh_out, alu_res;
    logic [STEP_W-1:0]  sh_step;
    logic               sh_dir, sh_arith;

    assign op         = alu_op_e'(i_alu_op);
    assign shamt      = i_operand_b[SHAMT_W-1:0];
    assign op_illegal = (i_alu_op > ALU_OP_W'(ALU_OP_LAST));
    assign o_ready    = (state_q == ST_IDLE) && (!o_valid || i_ready);
    assign accept     = i_valid && o_ready && !i_flush;

    alu_shift_step #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_shift_step (
        .work  (sh_in),
        .step  (sh_step),
        .dir   (sh_dir),
        .arith (sh_arith),
        .out   (sh_out)
    );

    // Shifter sees the raw operand with step=0 in IDLE (shamt=0 bypass), else the work reg
    always_comb begin
        sh_in    = i_operand_a;
        sh_step  = '0;
        sh_dir   = (op == ALU_SRL) || (op == ALU_SRA);
        sh_arith = (op == ALU_SRA);
        if (state_q == ST_SHIFT) begin
            sh_in    = work_q;
            sh_dir   = dir_q;
            sh_arith = arith_q;
            if (32'(rem_q) >= SHIFT_STEP) begin
                sh_step = STEP_W'(SHIFT_STEP);
            end else begin
                sh_step = STEP_W'(rem_q);
            end
        end
    end

    // Single-cycle result for the current input op
    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD:  alu_res = i_operand_a + i_operand_b;
            ALU_SUB:  alu_res = i_operand_a - i_operand_b;
            ALU_SLT:  alu_res = XLEN'($signed(i_operand_a) < $signed(i_operand_b));
            ALU_SLTU: alu_res = XLEN'(i_operand_a < i_operand_b);
            ALU_XOR:  alu_res = i_operand_a ^ i_operand_b;
            ALU_OR:   alu_res = i_operand_a | i_operand_b;
            ALU_AND:  alu_res = i_operand_a & i_operand_b;
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = sh_out;
            default:  alu_res = '0;
        endcase
    end

    // Next-state and output-register logic
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        rem_d     = rem_q;
        dir_d     = dir_q;
        arith_d   = arith_q;
        rd_d      = rd_q;
        valid_d   = o_valid && !i_ready;
        result_d  = o_result;
        out_rd_d  = o_rd;
        illegal_d = o_illegal;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!op_illegal && is_shift(op) && (shamt != '0)) begin
                        work_d  = i_operand_a;
                        rem_d   = shamt;
                        dir_d   = sh_dir;
                        arith_d = sh_arith;
                        rd_d    = i_rd;
                        state_d = ST_SHIFT;
                    end else begin
                        valid_d   = 1'b1;
                        result_d  = alu_res;
                        out_rd_d  = i_rd;
                        illegal_d = op_illegal;
                    end
                end
            end
            ST_SHIFT: begin
                work_d = sh_out;
                rem_d  = rem_q - SHAMT_W'(sh_step);
                if (rem_d == '0) begin
                    valid_d   = 1'b1;
                    result_d  = sh_out;
                    out_rd_d  = rd_q;
                    illegal_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (i_flush) begin
            valid_d = 1'b0;
            rem_d   = '0;
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            work_q    <= '0;
            rem_q     <= '0;
            dir_q     <= 1'b0;
            arith_q   <= 1'b0;
            rd_q      <= '0;
            o_valid   <= 1'b0;
            o_result  <= '0;
            o_rd      <= '0;
            o_illegal <= 1'b0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            rem_q     <= rem_d;
            dir_q     <= dir_d;
            arith_q   <= arith_d;
            rd_q      <= rd_d;
            o_valid   <= valid_d;
            o_result  <= result_d;
            o_rd      <= out_rd_d;
            o_illegal <= illegal_d;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed ops, latency, hold, flush and reset.
module tb_alu_exec_unit;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [3:0]  i_alu_op = '0;
    logic [31:0] i_operand_a = '0;
    logic [31:0] i_operand_b = '0;
    logic [4:0]  i_rd = '0;
    logic        o_ready, o_valid, o_illegal;
    logic [31:0] o_result;
    logic [4:0]  o_rd;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    alu_exec_unit #(.XLEN(32), .SHIFT_STEP(4), .RD_W(5)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_alu_op    (i_alu_op),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .i_rd        (i_rd),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_rd        (o_rd),
        .o_illegal   (o_illegal)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) tick();
    endtask

    // Present one op, wait (bounded) for o_ready, optionally push the expected result
    task automatic send(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [4:0] rd, input logic push, input logic [31:0] er,
                        input logic eill);
        int n = 0;
        while (!o_ready && n < 50) begin
            tick();
            n++;
        end
        chk("send_ready", {31'b0, o_ready}, 32'd1);
        i_valid     = 1'b1;
        i_alu_op    = op;
        i_operand_a = av;
        i_operand_b = bv;
        i_rd        = rd;
        if (push) q.push_back('{res: er, rd: rd, ill: eill});
        tick();
        i_valid = 1'b0;
    endtask

    // Cycles until o_valid, checking o_ready stays low while the shift runs
    task automatic wait_valid(input string name, input int exp_cyc);
        int   n = 0;
        logic rdy_seen = 1'b0;
        while (!o_valid && n < 60) begin
            if (o_ready) rdy_seen = 1'b1;
            tick();
            n++;
        end
        chk({name, "_lat"}, 32'(n), 32'(exp_cyc));
        chk({name, "_ready_low"}, {31'b0, rdy_seen}, 32'd0);
    endtask

    // Monitor: pop and compare on every output handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_valid && i_ready && !i_flush) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected actual=0x%08h rd=%0d required=no result", o_result, o_rd);
                end else begin
                    e = q.pop_front();
                    chk("sb_result", o_result, e.res);
                    chk("sb_rd", {27'b0, o_rd}, {27'b0, e.rd});
                    chk("sb_illegal", {31'b0, o_illegal}, {31'b0, e.ill});
                end
            end
        end
    end

    initial begin
        #12;
        chk("rst_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_result", o_result, 32'd0);
        chk("rst_rd", {27'b0, o_rd}, 32'd0);
        chk("rst_illegal", {31'b0, o_illegal}, 32'd0);
        chk("rst_ready", {31'b0, o_ready}, 32'd1);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        tick();

        // Wrap-around add/sub, back to back
        send(ALU_ADD, 32'hFFFF_FFFF, 32'd1, 5'd1, 1'b1, 32'h0000_0000, 1'b0);
        chk("add_lat", {31'b0, o_valid}, 32'd1);
        send(ALU_SUB, 32'd0, 32'd1, 5'd2, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("sub_lat", {31'b0, o_valid}, 32'd1);

        // Compares and logic ops
        send(ALU_SLT, 32'h8000_0000, 32'd1, 5'd3, 1'b1, 32'd1, 1'b0);
        send(ALU_SLTU, 32'h8000_0000, 32'd1, 5'd4, 1'b1, 32'd0, 1'b0);
        send(ALU_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 5'd5, 1'b1, 32'h0000_FF00, 1'b0);
        send(ALU_OR, 32'h0000_F0F0, 32'h0000_0FF0, 5'd6, 1'b1, 32'h0000_FFF0, 1'b0);
        send(ALU_AND, 32'h0000_F0F0, 32'h0000_0FF0, 5'd7, 1'b1, 32'h0000_00F0, 1'b0);
        chk("and_lat", {31'b0, o_valid}, 32'd1);

        // Shifts: 31 in 8 steps, 5 in 2 steps, 4 in 1 step, 0 as bypass
        send(ALU_SRA, 32'h8000_0000, 32'd31, 5'd8, 1'b1, 32'hFFFF_FFFF, 1'b0);
        wait_valid("sra31", 8);
        send(ALU_SRL, 32'h8000_0000, 32'd5, 5'd9, 1'b1, 32'h0400_0000, 1'b0);
        wait_valid("srl5", 2);
        send(ALU_SLL, 32'd1, 32'd4, 5'd10, 1'b1, 32'h0000_0010, 1'b0);
        wait_valid("sll4", 1);
        send(ALU_SLL, 32'h1234_5678, 32'h0000_0020, 5'd11, 1'b1, 32'h1234_5678, 1'b0);
        chk("sll0_lat", {31'b0, o_valid}, 32'd1);
        idle(1);

        // Backpressure hold then release with same-cycle accept
        i_ready = 1'b0;
        send(ALU_ADD, 32'd5, 32'd6, 5'd12, 1'b1, 32'd11, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'b0, o_valid}, 32'd1);
            chk("hold_result", o_result, 32'd11);
            chk("hold_rd", {27'b0, o_rd}, 32'd12);
            chk("hold_ready", {31'b0, o_ready}, 32'd0);
            tick();
        end
        i_ready = 1'b1;
        send(ALU_OR, 32'd1, 32'd2, 5'd13, 1'b1, 32'd3, 1'b0);
        chk("release_lat", {31'b0, o_valid}, 32'd1);
        idle(1);

        // Flush mid-shift
        send(ALU_SLL, 32'd1, 32'd31, 5'd14, 1'b0, 32'd0, 1'b0);
        idle(2);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("flush_shift_valid", {31'b0, o_valid}, 32'd0);
        chk("flush_shift_ready", {31'b0, o_ready}, 32'd1);
        idle(10);
        chk("flush_shift_dead", {31'b0, o_valid}, 32'd0);

        // Flush while holding a result
        i_ready = 1'b0;
        send(ALU_ADD, 32'd1, 32'd1, 5'd15, 1'b0, 32'd0, 1'b0);
        chk("flush_hold_pre", {31'b0, o_valid}, 32'd1);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("flush_hold_valid", {31'b0, o_valid}, 32'd0);
        chk("flush_hold_ready", {31'b0, o_ready}, 32'd1);

        // Flush beats an offered op
        i_ready     = 1'b1;
        i_flush     = 1'b1;
        i_valid     = 1'b1;
        i_alu_op    = ALU_ADD;
        i_operand_a = 32'd2;
        i_operand_b = 32'd2;
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flush_no_accept", {31'b0, o_valid}, 32'd0);

        // Illegal op, then a legal op clears the flag
        send(4'd12, 32'd5, 32'd6, 5'd16, 1'b1, 32'd0, 1'b1);
        chk("illegal_lat", {31'b0, o_valid}, 32'd1);
        send(ALU_ADD, 32'd9, 32'd9, 5'd17, 1'b1, 32'd18, 1'b0);
        idle(1);

        // Reset in the middle of a shift
        send(ALU_SRA, 32'h8000_0000, 32'd31, 5'd18, 1'b0, 32'd0, 1'b0);
        idle(3);
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_mid_result", o_result, 32'd0);
        chk("rst_mid_rd", {27'b0, o_rd}, 32'd0);
        chk("rst_mid_illegal", {31'b0, o_illegal}, 32'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        tick();
        send(ALU_ADD, 32'd3, 32'd4, 5'd19, 1'b1, 32'd7, 1'b0);
        chk("post_rst_lat", {31'b0, o_valid}, 32'd1);
        idle(3);
        chk("sb_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
